// File: rtl/demux_1_8_deser.sv
// 1-to-LANES serial deserializer: a lane counter steers valid bits into an assembly
// register; completed frames move to a valid/ready output holding register.
module demux_1_8_deser #(
    parameter int unsigned LANES = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [LANES-1:0] o,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [SEL_W-1:0] lane_sel,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);

    logic [0:0]       state, state_n;
    logic [SEL_W-1:0] count, count_n;
    logic [LANES-1:0] asm_q, asm_n;
    logic [LANES-1:0] o_n;
    logic             o_valid_n;
    logic             overflow_n;
    logic             frame_err_n;
    logic             complete;
    logic             load;
    logic             ovf_set;
    logic             ferr_set;

    // State, counter, assembly and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            asm_q     <= '0;
            o         <= '0;
            o_valid   <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            asm_q     <= asm_n;
            o         <= o_n;
            o_valid   <= o_valid_n;
            overflow  <= overflow_n;
            frame_err <= frame_err_n;
        end
    end

    // Next-state, lane steering, frame hand-off and sticky flags
    always_comb begin
        state_n     = state;
        count_n     = count;
        asm_n       = asm_q;
        complete    = 1'b0;
        ferr_set    = 1'b0;
        load        = 1'b0;
        ovf_set     = 1'b0;
        o_n         = o;
        o_valid_n   = o_valid;
        overflow_n  = overflow;
        frame_err_n = frame_err;

        case (state)
            IDLE: begin
                if (din_valid && sof) begin
                    asm_n[0] = din;
                    count_n  = SEL_W'(1);
                    state_n  = FILL;
                end
            end
            FILL: begin
                if (din_valid) begin
                    if (sof) begin
                        // Restart: partial frame is abandoned
                        ferr_set = 1'b1;
                        asm_n[0] = din;
                        count_n  = SEL_W'(1);
                    end else begin
                        asm_n[count] = din;
                        if (count == LAST_LANE) begin
                            complete = 1'b1;
                            count_n  = '0;
                            state_n  = IDLE;
                        end else begin
                            count_n = count + SEL_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase

        load    = complete && (!o_valid || o_ready);
        ovf_set = complete && o_valid && !o_ready;

        if (load) begin
            o_n       = asm_n;
            o_valid_n = 1'b1;
        end else if (o_valid && o_ready) begin
            o_valid_n = 1'b0;
        end

        // Set beats clear when both land on the same edge
        if (ovf_set)       overflow_n = 1'b1;
        else if (clr_err)  overflow_n = 1'b0;

        if (ferr_set)      frame_err_n = 1'b1;
        else if (clr_err)  frame_err_n = 1'b0;
    end

    assign lane_sel = count;

endmodule

// File: tb/tb_demux_1_8_deser.sv
// Directed bench for demux_1_8_deser with hand-computed expected words and flags.
module tb_demux_1_8_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       sof;
    logic [7:0] o;
    logic       o_valid;
    logic       o_ready;
    logic [2:0] lane_sel;
    logic       overflow;
    logic       frame_err;
    logic       clr_err;

    int checks = 0;
    int errors = 0;

    demux_1_8_deser #(.LANES(8), .SEL_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .sof       (sof),
        .o         (o),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .lane_sel  (lane_sel),
        .overflow  (overflow),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        din_valid = 1'b0;
        sof       = 1'b0;
        din       = 1'b0;
        tick();
    endtask

    // Send lanes lo..hi of w; sof on lane 0; optional idle gap after lanes in gap mask
    task automatic send_lanes(input logic [7:0] w, input int lo, input int hi, input logic [7:0] gap);
        for (int k = lo; k <= hi; k++) begin
            din       = w[k];
            sof       = (k == 0);
            din_valid = 1'b1;
            tick();
            if (gap[k]) begin
                idle();
                chk("gap_lane_hold", 32'(lane_sel), 32'((k + 1) % 8));
            end
        end
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sof = 1'b0; o_ready = 1'b0; clr_err = 1'b0;

        // T1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            din = 1'($urandom); din_valid = 1'($urandom); sof = 1'($urandom);
            o_ready = 1'($urandom); clr_err = 1'($urandom);
            tick();
        end
        chk("rst_o", 32'(o), 32'h0);
        chk("rst_o_valid", 32'(o_valid), 32'h0);
        chk("rst_lane_sel", 32'(lane_sel), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0; din = 1'b0; din_valid = 1'b0; sof = 1'b0; o_ready = 1'b1; clr_err = 1'b0;
        idle();

        // IDLE drops bits without sof
        din = 1'b1; din_valid = 1'b1; sof = 1'b0;
        tick(); tick();
        chk("idle_drop_lane", 32'(lane_sel), 32'h0);
        chk("idle_drop_ferr", 32'(frame_err), 32'h0);
        idle();

        // T2: basic frame 4D
        send_lanes(8'h4D, 0, 0, 8'h00);
        chk("t2_lane_after_sof", 32'(lane_sel), 32'h1);
        chk("t2_valid_mid", 32'(o_valid), 32'h0);
        send_lanes(8'h4D, 1, 7, 8'h00);
        chk("t2_o", 32'(o), 32'h4D);
        chk("t2_o_valid", 32'(o_valid), 32'h1);
        chk("t2_lane_wrap", 32'(lane_sel), 32'h0);
        idle();
        chk("t2_o_valid_drop", 32'(o_valid), 32'h0);
        chk("t2_o_hold", 32'(o), 32'h4D);

        // T3: stalls, then backpressure overflow
        send_lanes(8'h4D, 0, 7, 8'b0010_0100);
        chk("t3_o", 32'(o), 32'h4D);
        chk("t3_o_valid", 32'(o_valid), 32'h1);
        o_ready = 1'b0;
        send_lanes(8'hA5, 0, 7, 8'h00);
        chk("t3_overflow", 32'(overflow), 32'h1);
        chk("t3_o_kept", 32'(o), 32'h4D);
        chk("t3_o_valid_kept", 32'(o_valid), 32'h1);
        o_ready = 1'b1;
        idle();
        chk("t3_accept", 32'(o_valid), 32'h0);
        clr_err = 1'b1;
        idle();
        clr_err = 1'b0;
        chk("t3_clr_overflow", 32'(overflow), 32'h0);

        // T4: sof at lane 4, then full frame 3C
        send_lanes(8'hFF, 0, 3, 8'h00);
        chk("t4_lane4", 32'(lane_sel), 32'h4);
        send_lanes(8'h3C, 0, 0, 8'h00);
        chk("t4_frame_err", 32'(frame_err), 32'h1);
        chk("t4_restart_lane", 32'(lane_sel), 32'h1);
        chk("t4_no_partial", 32'(o_valid), 32'h0);
        send_lanes(8'h3C, 1, 7, 8'h00);
        chk("t4_o", 32'(o), 32'h3C);
        chk("t4_o_valid", 32'(o_valid), 32'h1);
        clr_err = 1'b1;
        idle();
        clr_err = 1'b0;
        chk("t4_clr_ferr", 32'(frame_err), 32'h0);
        // Set and clear on the same edge: set wins
        send_lanes(8'h00, 0, 1, 8'h00);
        clr_err = 1'b1;
        send_lanes(8'h00, 0, 0, 8'h00);
        clr_err = 1'b0;
        chk("t4_set_wins", 32'(frame_err), 32'h1);
        clr_err = 1'b1;
        idle();
        clr_err = 1'b0;
        chk("t4_clr_again", 32'(frame_err), 32'h0);

        // T5: back-to-back 0F then F0
        send_lanes(8'h0F, 0, 7, 8'h00);
        chk("t5_o_0f", 32'(o), 32'h0F);
        chk("t5_v_0f", 32'(o_valid), 32'h1);
        send_lanes(8'hF0, 0, 0, 8'h00);
        chk("t5_accept", 32'(o_valid), 32'h0);
        send_lanes(8'hF0, 1, 7, 8'h00);
        chk("t5_o_f0", 32'(o), 32'hF0);
        chk("t5_v_f0", 32'(o_valid), 32'h1);
        chk("t5_no_ovf", 32'(overflow), 32'h0);
        // Load and accept on the same edge
        o_ready = 1'b0;
        send_lanes(8'h66, 0, 6, 8'h00);
        chk("t5_held_f0", 32'(o), 32'hF0);
        o_ready = 1'b1;
        send_lanes(8'h66, 7, 7, 8'h00);
        chk("t5_o_66", 32'(o), 32'h66);
        chk("t5_v_66", 32'(o_valid), 32'h1);
        chk("t5_no_ovf2", 32'(overflow), 32'h0);
        idle();
        chk("t5_drain", 32'(o_valid), 32'h0);

        // T6: reset at lane 5, then frame 81
        send_lanes(8'hFF, 0, 4, 8'h00);
        chk("t6_lane5", 32'(lane_sel), 32'h5);
        rst = 1'b1;
        din = 1'b1; din_valid = 1'b1;
        tick();
        rst = 1'b0;
        din_valid = 1'b0;
        chk("t6_rst_lane", 32'(lane_sel), 32'h0);
        chk("t6_rst_o", 32'(o), 32'h0);
        chk("t6_rst_valid", 32'(o_valid), 32'h0);
        send_lanes(8'h81, 0, 7, 8'h00);
        chk("t6_o", 32'(o), 32'h81);
        chk("t6_v", 32'(o_valid), 32'h1);
        chk("t6_ferr", 32'(frame_err), 32'h0);
        idle();
        chk("t6_drain", 32'(o_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
